// File: rtl/rr_mesh_arbiter.sv
// Round-robin arbiter plus show-ahead egress FIFO for one mesh node terminal.
// Optional destination filtering is enabled with the ARB_ID_FILTER_EN macro.
module rr_mesh_arbiter #(
    parameter int pckg_sz  = 40,
    parameter int Fif_Size = 10,
    parameter int channels = 4,
    parameter int id_r     = 0,
    parameter int id_c     = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [channels-1:0]                pndng_i,
    input  logic [channels*pckg_sz-1:0]        Data_out_i,
    output logic [channels-1:0]                pop_i,
    output logic [$clog2(channels)-1:0]        Trn,
    output logic [pckg_sz-1:0]                 Data_out,
    output logic                               pndng,
    input  logic                               pop,
    output logic                               full,
    output logic [$clog2(Fif_Size+1)-1:0]      count
);

    localparam int CW = $clog2(channels);
    localparam int NW = $clog2(Fif_Size + 1);
    localparam int PW = (Fif_Size > 1) ? $clog2(Fif_Size) : 1;

    localparam logic [NW-1:0] DEPTH   = NW'(Fif_Size);
    localparam logic [PW-1:0] LAST    = PW'(Fif_Size - 1);
    localparam logic [7:0]    NODE_ID = {4'(id_r), 4'(id_c)};

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    function automatic logic header_match(input logic [pckg_sz-1:0] pkt);
        return pkt[pckg_sz-1 -: 8] == NODE_ID;
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic [channels-1:0]   pop_i_q, pop_i_d;
    logic [CW-1:0]         trn_q, trn_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [NW-1:0]         count_q, count_d;
    logic                  full_q, pndng_q;
    logic [pckg_sz-1:0]    head_q, head_d;
    logic [pckg_sz-1:0]    mem_q [Fif_Size];

    logic [CW-1:0]         win_idx_s;
    logic [CW-1:0]         cand_s;
    logic                  any_s;
    logic [pckg_sz-1:0]    win_pkt_s;
    logic                  hdr_match_s;
    logic                  wr_ok_s;
    logic                  room_s;
    logic                  grant_s;
    logic                  push_s;
    logic                  pop_eff_s;

    // Winner search: descending scan so the first pending channel at or after ptr wins.
    always_comb begin
        win_idx_s = ptr_q;
        cand_s    = {CW{1'b0}};
        for (int i = channels - 1; i >= 0; i--) begin
            cand_s    = CW'((int'(ptr_q) + i) % channels);
            win_idx_s = pndng_i[cand_s] ? cand_s : win_idx_s;
        end
        any_s       = |pndng_i;
        win_pkt_s   = Data_out_i[win_idx_s*pckg_sz +: pckg_sz];
        hdr_match_s = header_match(win_pkt_s);
        room_s      = (count_q < DEPTH);
`ifdef ARB_ID_FILTER_EN
        wr_ok_s     = hdr_match_s;
`else
        // Header is deliberately ignored without filtering.
        wr_ok_s     = hdr_match_s | 1'b1;
`endif
    end

    // Arbitration FSM next state and registered grant outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        trn_d   = trn_q;
        pop_i_d = {channels{1'b0}};
        grant_s = 1'b0;
        push_s  = 1'b0;
        case (state_q)
            ST_ARB: begin
                grant_s = any_s && (room_s || !wr_ok_s);
                if (grant_s) begin
                    push_s  = wr_ok_s;
                    pop_i_d = {{(channels-1){1'b0}}, 1'b1} << win_idx_s;
                    trn_d   = win_idx_s;
                    ptr_d   = CW'((int'(win_idx_s) + 1) % channels);
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_HOLD: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Egress FIFO pointer, occupancy and next-head computation.
    always_comb begin
        pop_eff_s = pop && pndng_q;
        rd_d      = pop_eff_s ? wrap_inc(rd_q) : rd_q;
        wr_d      = push_s ? wrap_inc(wr_q) : wr_q;
        case ({push_s, pop_eff_s})
            2'b10:   count_d = count_q + NW'(1'b1);
            2'b01:   count_d = count_q - NW'(1'b1);
            default: count_d = count_q;
        endcase
        // A push into an otherwise-empty queue becomes the new head directly.
        if (count_d == {NW{1'b0}}) begin
            head_d = {pckg_sz{1'b0}};
        end else if (push_s && (wr_q == rd_d)) begin
            head_d = win_pkt_s;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
            ptr_q   <= {CW{1'b0}};
            trn_q   <= {CW{1'b0}};
            pop_i_q <= {channels{1'b0}};
            rd_q    <= {PW{1'b0}};
            wr_q    <= {PW{1'b0}};
            count_q <= {NW{1'b0}};
            full_q  <= 1'b0;
            pndng_q <= 1'b0;
            head_q  <= {pckg_sz{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            trn_q   <= trn_d;
            pop_i_q <= pop_i_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
            pndng_q <= (count_d != {NW{1'b0}});
            head_q  <= head_d;
        end
    end

    // Packet storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= win_pkt_s;
        end
    end

    assign pop_i    = pop_i_q;
    assign Trn      = trn_q;
    assign Data_out = head_q;
    assign pndng    = pndng_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: tb/tb_rr_mesh_arbiter.sv
// Self-checking bench for rr_mesh_arbiter: directed table, corner sequences, random vs. queue model.
module tb_rr_mesh_arbiter;

    localparam int PS = 40;
    localparam int FS = 10;
    localparam int CH = 4;
`ifdef ARB_ID_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   pndng_i;
    logic [CH*PS-1:0] Data_out_i;
    logic [CH-1:0]   pop_i;
    logic [1:0]      Trn;
    logic [PS-1:0]   Data_out;
    logic            pndng;
    logic            pop;
    logic            full;
    logic [3:0]      count;

    always #5 clk = ~clk;

    rr_mesh_arbiter #(
        .pckg_sz(PS), .Fif_Size(FS), .channels(CH), .id_r(2), .id_c(3)
    ) dut (
        .clk(clk), .rst(rst), .pndng_i(pndng_i), .Data_out_i(Data_out_i),
        .pop_i(pop_i), .Trn(Trn), .Data_out(Data_out), .pndng(pndng),
        .pop(pop), .full(full), .count(count)
    );

    int checks = 0;
    int errors = 0;

    // stimulus variables
    logic [CH-1:0] pend_v;
    logic [PS-1:0] dat_v [CH];
    logic          pop_v;

    // reference model: egress queue plus turn bookkeeping
    logic [PS-1:0] mq [$];
    int            m_ptr, m_trn;
    bit            m_cool;
    logic [CH-1:0] m_popi;

    // upstream input FIFOs for random phase
    logic [PS-1:0] qin [CH][$];

    typedef struct {
        logic [CH-1:0] pend;
        logic          pop;
        logic [CH-1:0] exp_popi;
        logic [1:0]    exp_trn;
        int            exp_cnt;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ptr = 0; m_trn = 0; m_cool = 1'b0; m_popi = '0;
    endtask

    task automatic compare_model();
        chk("pop_i", 64'(pop_i), 64'(m_popi));
        chk("Trn", 64'(Trn), 64'(m_trn));
        chk("count", 64'(count), 64'(mq.size()));
        chk("pndng", 64'(pndng), 64'(mq.size() > 0));
        chk("full", 64'(full), 64'(mq.size() == FS));
        chk("Data_out", 64'(Data_out), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    endtask

    // One clock: evaluate model from the applied inputs, clock the DUT, compare.
    task automatic tick();
        int  w;
        bit  match;
        bit  grant;
        grant = 1'b0;
        match = 1'b1;
        w = 0;
        if (!m_cool && pend_v != '0) begin
            for (int i = CH - 1; i >= 0; i--) begin
                if (pend_v[(m_ptr + i) % CH]) w = (m_ptr + i) % CH;
            end
            match = !FILT || (dat_v[w][PS-1 -: 8] == 8'h23);
            grant = !match || (mq.size() < FS);
        end
        if (pop_v && mq.size() > 0) void'(mq.pop_front());
        if (grant) begin
            if (match) mq.push_back(dat_v[w]);
            m_popi = CH'(1) << w;
            m_trn  = w;
            m_ptr  = (w + 1) % CH;
            m_cool = 1'b1;
        end else begin
            m_popi = '0;
            m_cool = 1'b0;
        end
        pndng_i = pend_v;
        for (int k = 0; k < CH; k++) Data_out_i[k*PS +: PS] = dat_v[k];
        pop = pop_v;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        pndng_i = '1;
        pop = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async_pop_i", 64'(pop_i), 64'd0);
        chk("rst_async_count", 64'(count), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_pop_i", 64'(pop_i), 64'd0);
        chk("rst_hold_count", 64'(count), 64'd0);
        chk("rst_hold_pndng", 64'(pndng), 64'd0);
        chk("rst_hold_Trn", 64'(Trn), 64'd0);
        chk("rst_hold_Data_out", 64'(Data_out), 64'd0);
        chk("rst_hold_full", 64'(full), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        int grants, first_cyc, second_cyc, c0;
        int order [$];
        logic [CH-1:0] pb;

        rst = 1'b0; pop = 1'b0; pndng_i = '1; Data_out_i = '0;
        pop_v = 1'b0; pend_v = '0;
        for (int k = 0; k < CH; k++) dat_v[k] = {8'h23, 24'h0, 8'(k)};
        model_reset();
        @(posedge clk); #1;
        do_reset();

        tbl[0]  = '{4'hF, 1'b0, 4'h1, 2'd0, 1};
        tbl[1]  = '{4'hF, 1'b0, 4'h0, 2'd0, 1};
        tbl[2]  = '{4'hF, 1'b0, 4'h2, 2'd1, 2};
        tbl[3]  = '{4'hF, 1'b0, 4'h0, 2'd1, 2};
        tbl[4]  = '{4'hA, 1'b0, 4'h8, 2'd3, 3};
        tbl[5]  = '{4'hA, 1'b1, 4'h0, 2'd3, 2};
        tbl[6]  = '{4'hA, 1'b1, 4'h2, 2'd1, 2};
        tbl[7]  = '{4'hA, 1'b0, 4'h0, 2'd1, 2};
        tbl[8]  = '{4'hA, 1'b0, 4'h8, 2'd3, 3};
        tbl[9]  = '{4'h0, 1'b0, 4'h0, 2'd3, 3};
        tbl[10] = '{4'h0, 1'b0, 4'h0, 2'd3, 3};
        tbl[11] = '{4'h0, 1'b1, 4'h0, 2'd3, 2};
        tbl[12] = '{4'h0, 1'b1, 4'h0, 2'd3, 1};
        tbl[13] = '{4'h0, 1'b1, 4'h0, 2'd3, 0};
        tbl[14] = '{4'h0, 1'b1, 4'h0, 2'd3, 0};
        for (int r = 0; r < 15; r++) begin
            pend_v = tbl[r].pend;
            pop_v  = tbl[r].pop;
            tick();
            chk($sformatf("tbl%0d_pop_i", r), 64'(pop_i), 64'(tbl[r].exp_popi));
            chk($sformatf("tbl%0d_Trn", r), 64'(Trn), 64'(tbl[r].exp_trn));
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].exp_cnt));
        end
        chk("empty_pop_Data_out", 64'(Data_out), 64'd0);

        // Fill to full with all channels pending and no consumer.
        pend_v = 4'hF; pop_v = 1'b0;
        grants = 0; first_cyc = -1; second_cyc = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (pop_i != '0) begin
                grants++;
                order.push_back(int'(Trn));
                if (first_cyc < 0) first_cyc = c;
                else if (second_cyc < 0) second_cyc = c;
            end
        end
        chk("full_grants", 64'(grants), 64'd10);
        chk("full_flag", 64'(full), 64'd1);
        chk("rr_spacing", 64'(second_cyc - first_cyc), 64'd2);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 4));
        pop_v = 1'b1; tick();
        chk("after_pop_count", 64'(count), 64'd9);
        chk("after_pop_no_grant", 64'(pop_i), 64'd0);
        pop_v = 1'b0; tick();
        chk("refill_grant", 64'(pop_i != '0), 64'd1);
        chk("refill_count", 64'(count), 64'd10);

        // Drain to 5, then push and pop in the same edge.
        pend_v = 4'h0; pop_v = 1'b1;
        repeat (5) tick();
        chk("drain_count", 64'(count), 64'd5);
        pend_v = 4'hF; tick();
        chk("pushpop_count", 64'(count), 64'd5);
        chk("pushpop_grant", 64'(pop_i != '0), 64'd1);
        pend_v = 4'h0; pop_v = 1'b0; tick();

`ifdef ARB_ID_FILTER_EN
        c0 = int'(count);
        pend_v = 4'b0011;
        dat_v[0] = {8'h11, 32'h0000_0AAA};
        dat_v[1] = {8'h23, 32'h0000_0BBB};
        repeat (4) tick();
        chk("filter_count_delta", 64'(int'(count) - c0), 64'd1);
        pend_v = 4'h0;
`endif

        // Randomised traffic from upstream queues, with a reset mid-run.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                @(posedge clk); #1;
                do_reset();
            end
            for (int k = 0; k < CH; k++) begin
                if (qin[k].size() < 4 && $urandom_range(0, 2) == 0)
                    qin[k].push_back({($urandom_range(0, 1) == 0) ? 8'h23 : 8'h11, 32'($urandom)});
                pend_v[k] = (qin[k].size() > 0);
                dat_v[k]  = (qin[k].size() > 0) ? qin[k][0] : '0;
            end
            pop_v = ($urandom_range(0, 2) != 0);
            pb = pop_i;
            tick();
            for (int k = 0; k < CH; k++)
                if (pb[k] && qin[k].size() > 0) void'(qin[k].pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
